// File: rtl/mem_access_stage_pkg.sv
// Shared encodings and lane helpers for the memory access stage.
// Lane logic assumes a 32-bit data word with 4 byte lanes.
package mem_access_stage_pkg;

    localparam logic [1:0] MEM_BYTE = 2'd0;
    localparam logic [1:0] MEM_HALF = 2'd1;
    localparam logic [1:0] MEM_WORD = 2'd2;

    typedef enum logic {
        MAS_IDLE   = 1'b0,
        MAS_ACCESS = 1'b1
    } mas_state_t;

    // Length 3 is never legal; halves need an even address, words a 4-byte boundary.
    function automatic logic access_aligned(input logic [1:0] len, input logic [1:0] lane);
        logic ok;
        ok = 1'b0;
        case (len)
            MEM_BYTE: ok = 1'b1;
            MEM_HALF: ok = ~lane[0];
            MEM_WORD: ok = (lane == 2'b00);
            default:  ok = 1'b0;
        endcase
        return ok;
    endfunction

    function automatic logic [3:0] lane_byte_en(input logic [1:0] len, input logic [1:0] lane);
        logic [3:0] be;
        be = 4'b0000;
        case (len)
            MEM_BYTE: be = 4'b0001 << lane;
            MEM_HALF: be = lane[1] ? 4'b1100 : 4'b0011;
            MEM_WORD: be = 4'b1111;
            default:  be = 4'b0000;
        endcase
        return be;
    endfunction

    // Replicate the low byte/half across the word so any enabled lane sees the right bits.
    function automatic logic [31:0] store_replicate(input logic [1:0] len, input logic [31:0] d);
        logic [31:0] w;
        w = d;
        case (len)
            MEM_BYTE: w = {4{d[7:0]}};
            MEM_HALF: w = {2{d[15:0]}};
            default:  w = d;
        endcase
        return w;
    endfunction

endpackage

// File: rtl/mem_access_stage_load_align.sv
// Combinational load extraction: picks the addressed byte/half out of the read
// word and sign- or zero-extends it. Word loads pass through unchanged.
module load_align
    import mem_access_stage_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic [DATA_WIDTH-1:0] rdata,
    input  logic [1:0]            lane,
    input  logic [1:0]            length,
    input  logic                  is_unsigned,
    output logic [DATA_WIDTH-1:0] data
);

    logic [DATA_WIDTH-1:0] shifted;

    always_comb begin
        shifted = rdata >> {lane, 3'b000};
        data    = shifted;
        case (length)
            MEM_BYTE: data = is_unsigned ? {{(DATA_WIDTH-8){1'b0}}, shifted[7:0]}
                                         : {{(DATA_WIDTH-8){shifted[7]}}, shifted[7:0]};
            MEM_HALF: data = is_unsigned ? {{(DATA_WIDTH-16){1'b0}}, shifted[15:0]}
                                         : {{(DATA_WIDTH-16){shifted[15]}}, shifted[15:0]};
            default:  data = shifted;
        endcase
    end

endmodule

// File: rtl/mem_access_stage.sv
// Memory stage: one outstanding data-memory access, byte-lane steering, load
// extension and a registered writeback packet; stalls upstream while busy.
module mem_access_stage
    import mem_access_stage_pkg::*;
#(
    parameter int DATA_WIDTH    = 32,
    parameter int REGADDR_WIDTH = 5,
    parameter int ADDR_WIDTH    = 32
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     valid_in,
    input  logic                     load_in,
    input  logic                     loadUnsigned_in,
    input  logic                     store_in,
    input  logic [1:0]               memLength_in,
    input  logic [ADDR_WIDTH-1:0]    addr_in,
    input  logic [DATA_WIDTH-1:0]    storeData_in,
    input  logic [REGADDR_WIDTH-1:0] writeSelect_in,
    input  logic                     writeEnable_in,
    output logic                     stall_out,
    output logic                     mem_req,
    output logic                     mem_we,
    output logic [ADDR_WIDTH-1:0]    mem_addr,
    output logic [DATA_WIDTH-1:0]    mem_wdata,
    output logic [3:0]               mem_byteEn,
    input  logic                     mem_ready,
    input  logic [DATA_WIDTH-1:0]    mem_rdata,
    output logic                     wb_valid,
    output logic                     wb_en,
    output logic [REGADDR_WIDTH-1:0] wb_sel,
    output logic [DATA_WIDTH-1:0]    wb_data,
    output logic                     misaligned_out
);

    // Bus handshake: mem_req rises the cycle after capture and stays high, with
    // address/data/enables stable, until the first cycle mem_ready is sampled
    // high; that cycle completes the access and mem_rdata is valid with it.
    // mem_ready outside ACCESS is ignored.

    mas_state_t state, state_d;

    logic [ADDR_WIDTH-1:0]    addr_q,  addr_d;
    logic [1:0]               lane_q,  lane_d;
    logic [1:0]               len_q,   len_d;
    logic                     uns_q,   uns_d;
    logic [REGADDR_WIDTH-1:0] rd_q,    rd_d;
    logic                     rd_we_q, rd_we_d;
    logic                     we_q,    we_d;
    logic [DATA_WIDTH-1:0]    wdata_q, wdata_d;
    logic [3:0]               be_q,    be_d;

    logic                     wb_valid_q, wb_valid_d;
    logic                     wb_en_q,    wb_en_d;
    logic [REGADDR_WIDTH-1:0] wb_sel_q,   wb_sel_d;
    logic [DATA_WIDTH-1:0]    wb_data_q,  wb_data_d;
    logic                     mis_q,      mis_d;

    logic [DATA_WIDTH-1:0]    load_data;
    logic                     is_mem_op;
    logic                     in_access;

    load_align #(.DATA_WIDTH(DATA_WIDTH)) u_load_align (
        .rdata       (mem_rdata),
        .lane        (lane_q),
        .length      (len_q),
        .is_unsigned (uns_q),
        .data        (load_data)
    );

    assign is_mem_op = load_in | store_in;

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= MAS_IDLE;
            addr_q     <= '0;
            lane_q     <= '0;
            len_q      <= '0;
            uns_q      <= 1'b0;
            rd_q       <= '0;
            rd_we_q    <= 1'b0;
            we_q       <= 1'b0;
            wdata_q    <= '0;
            be_q       <= '0;
            wb_valid_q <= 1'b0;
            wb_en_q    <= 1'b0;
            wb_sel_q   <= '0;
            wb_data_q  <= '0;
            mis_q      <= 1'b0;
        end else begin
            state      <= state_d;
            addr_q     <= addr_d;
            lane_q     <= lane_d;
            len_q      <= len_d;
            uns_q      <= uns_d;
            rd_q       <= rd_d;
            rd_we_q    <= rd_we_d;
            we_q       <= we_d;
            wdata_q    <= wdata_d;
            be_q       <= be_d;
            wb_valid_q <= wb_valid_d;
            wb_en_q    <= wb_en_d;
            wb_sel_q   <= wb_sel_d;
            wb_data_q  <= wb_data_d;
            mis_q      <= mis_d;
        end
    end

    always_comb begin
        state_d    = state;
        addr_d     = addr_q;
        lane_d     = lane_q;
        len_d      = len_q;
        uns_d      = uns_q;
        rd_d       = rd_q;
        rd_we_d    = rd_we_q;
        we_d       = we_q;
        wdata_d    = wdata_q;
        be_d       = be_q;
        wb_valid_d = 1'b0;
        wb_en_d    = 1'b0;
        wb_sel_d   = wb_sel_q;
        wb_data_d  = wb_data_q;
        mis_d      = 1'b0;

        case (state)
            MAS_IDLE: begin
                if (valid_in) begin
                    wb_sel_d = writeSelect_in;
                    if (load_in && store_in) begin
                        // Contradictory frame: retire it without touching the bus or the register file.
                        wb_valid_d = 1'b1;
                        wb_data_d  = '0;
                    end else if (is_mem_op) begin
                        if (access_aligned(memLength_in, addr_in[1:0])) begin
                            state_d = MAS_ACCESS;
                            addr_d  = {addr_in[ADDR_WIDTH-1:2], 2'b00};
                            lane_d  = addr_in[1:0];
                            len_d   = memLength_in;
                            uns_d   = loadUnsigned_in;
                            rd_d    = writeSelect_in;
                            rd_we_d = writeEnable_in;
                            we_d    = store_in;
                            wdata_d = store_replicate(memLength_in, storeData_in);
                            be_d    = lane_byte_en(memLength_in, addr_in[1:0]);
                        end else begin
                            mis_d      = 1'b1;
                            wb_valid_d = 1'b1;
                            wb_data_d  = '0;
                        end
                    end else begin
                        wb_valid_d = 1'b1;
                        wb_en_d    = writeEnable_in & (writeSelect_in != '0);
                        wb_data_d  = DATA_WIDTH'(addr_in);
                    end
                end
            end
            MAS_ACCESS: begin
                if (mem_ready) begin
                    state_d    = MAS_IDLE;
                    wb_valid_d = 1'b1;
                    wb_sel_d   = rd_q;
                    wb_en_d    = ~we_q & rd_we_q & (rd_q != '0);
                    wb_data_d  = we_q ? '0 : load_data;
                end
            end
            default: state_d = MAS_IDLE;
        endcase
    end

    // Bus and stall outputs come straight off the state and capture registers.
    assign in_access      = (state == MAS_ACCESS);
    assign stall_out      = in_access;
    assign mem_req        = in_access;
    assign mem_we         = in_access & we_q;
    assign mem_addr       = in_access ? addr_q  : '0;
    assign mem_wdata      = in_access ? wdata_q : '0;
    assign mem_byteEn     = in_access ? be_q    : '0;

    assign wb_valid       = wb_valid_q;
    assign wb_en          = wb_en_q;
    assign wb_sel         = wb_sel_q;
    assign wb_data        = wb_data_q;
    assign misaligned_out = mis_q;

endmodule
